// File: rtl/glitch_trig_delay_if.sv
// Port bundle for glitch_trig_delay: control/pin inputs and trigger/status outputs.
interface glitch_trig_delay_if #(
  parameter int unsigned DELAY_W = 16
);
  logic               arm;
  logic               abort;
  logic               ext_trig;
  logic               target_clock;
  logic [DELAY_W-1:0] delay;
  logic               trig;
  logic               armed;
  logic               busy;
  logic [7:0]         fire_count;

  modport master (
    output arm, abort, ext_trig, target_clock, delay,
    input  trig, armed, busy, fire_count
  );

  modport slave (
    input  arm, abort, ext_trig, target_clock, delay,
    output trig, armed, busy, fire_count
  );
endinterface

// File: rtl/glitch_trig_delay.sv
// Trigger delay for the clock-glitch chain: ext_trig edge -> N target-clock edges -> trig pulse.
// Optional GLITCH_TRIG_REARM_EN: HOLDOFF returns to ARMED instead of IDLE.
module glitch_trig_delay #(
  parameter int unsigned DELAY_W     = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  glitch_trig_delay_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned FC_W   = 8;
  localparam logic [FC_W-1:0] FC_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_FIRE,
    S_HOLDOFF
  } state_t;

`ifdef GLITCH_TRIG_REARM_EN
  localparam state_t HOLDOFF_EXIT = S_ARMED;
`else
  localparam state_t HOLDOFF_EXIT = S_IDLE;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic [SYNC_STAGES-1:0] tclk_sync_q, tclk_sync_d;
  logic                   ext_prev_q, ext_prev_d;
  logic                   tclk_prev_q, tclk_prev_d;
  logic [DELAY_W-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [FC_W-1:0]        fire_count_q, fire_count_d;
  logic                   trig_q, trig_d;
  logic                   armed_q, armed_d;
  logic                   busy_q, busy_d;

  logic ext_level_c;
  logic trig_rise_c;
  logic tclk_rise_c;
  logic hold_last_c;

  // Synchroniser chains plus one "previous" flop each for single-cycle edge pulses.
  always_comb begin
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], bus.ext_trig};
    tclk_sync_d = {tclk_sync_q[SYNC_STAGES-2:0], bus.target_clock};
    ext_prev_d  = ext_sync_q[SYNC_STAGES-1];
    tclk_prev_d = tclk_sync_q[SYNC_STAGES-1];
    ext_level_c = ext_sync_q[SYNC_STAGES-1];
    trig_rise_c = ext_sync_q[SYNC_STAGES-1] & ~ext_prev_q;
    tclk_rise_c = tclk_sync_q[SYNC_STAGES-1] & ~tclk_prev_q;
    hold_last_c = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (bus.arm) state_d = S_ARMED;
        S_ARMED:   if (trig_rise_c) state_d = (bus.delay == '0) ? S_FIRE : S_DELAY;
        S_DELAY:   if (tclk_rise_c && (cnt_q <= DELAY_W'(1))) state_d = S_FIRE;
        S_FIRE:    if (tclk_rise_c && hold_last_c) state_d = S_HOLDOFF;
        S_HOLDOFF: if (!ext_level_c) state_d = HOLDOFF_EXIT;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered decodes of the next state.
  always_comb begin
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    fire_count_d = fire_count_q;
    trig_d       = (state_d == S_FIRE);
    armed_d      = (state_d == S_ARMED);
    busy_d       = (state_d == S_DELAY) || (state_d == S_FIRE) || (state_d == S_HOLDOFF);

    if ((state_q == S_ARMED) && (state_d == S_DELAY)) begin
      cnt_d = bus.delay;
    end else if ((state_q == S_DELAY) && tclk_rise_c && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end

    // Hold counter sits at zero outside FIRE, so it is clear on every entry.
    if (state_q != S_FIRE) begin
      hold_d = '0;
    end else if (tclk_rise_c) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    if ((state_q == S_FIRE) && (state_d == S_HOLDOFF) && (fire_count_q != FC_MAX)) begin
      fire_count_d = fire_count_q + FC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync_q   <= '0;
      tclk_sync_q  <= '0;
      ext_prev_q   <= 1'b0;
      tclk_prev_q  <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      fire_count_q <= '0;
      trig_q       <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ext_sync_q   <= ext_sync_d;
      tclk_sync_q  <= tclk_sync_d;
      ext_prev_q   <= ext_prev_d;
      tclk_prev_q  <= tclk_prev_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      fire_count_q <= fire_count_d;
      trig_q       <= trig_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.trig       = trig_q;
  assign bus.armed      = armed_q;
  assign bus.busy       = busy_q;
  assign bus.fire_count = fire_count_q;

endmodule
